// File: rtl/uart_pkg.sv
// Shared types for the UART receiver: parity mode, receiver FSM states and the
// buffered frame entry, plus the parity helper used when a frame completes.
package uart_pkg;

  localparam int MAX_DATA_WIDTH = 9;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_e;

  typedef struct packed {
    logic                      brk;
    logic                      frame_err;
    logic                      parity_err;
    logic [MAX_DATA_WIDTH-1:0] data;
  } rx_entry_t;

  // Expected parity bit; zero-extended data does not change the XOR reduction.
  function automatic logic expected_parity(input parity_e mode,
                                           input logic [MAX_DATA_WIDTH-1:0] d);
    return (mode == PAR_ODD) ? ~^d : ^d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_core_if.sv
// Stream interface carrying the head-of-FIFO frame and its status flags to the consumer.
interface uart_rx_fifo_core_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_parity_err;
  logic                  m_frame_err;
  logic                  m_break;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    output m_data, m_parity_err, m_frame_err, m_break, m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data, m_parity_err, m_frame_err, m_break, m_valid,
    output m_ready
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// Generic show-ahead FIFO: the head word is visible whenever the FIFO is not empty.
// A write into a full FIFO is accepted only if a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid_i,
  input  logic [WIDTH-1:0]         in_data_i,
  input  logic                     out_ready_i,
  output logic [WIDTH-1:0]         out_data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             do_pop, do_push;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_pop  = out_ready_i && !empty_o;
  assign do_push = in_valid_i && (!full_o || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      level_q <= level_q + 1'b1;
      else if (do_pop && !do_push) level_q <= level_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= in_data_i;
  end

  // Gate the head so an empty FIFO presents zeros rather than stale storage.
  assign out_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o    = level_q;

endmodule

// File: rtl/uart_rx_fifo_core.sv
// Oversampling UART receiver with synchroniser, 3-sample majority vote, parity/framing/break
// detection, feeding a show-ahead FIFO exposed on a valid/ready stream interface.
module uart_rx_fifo_core
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        baud_tick,
  input  logic                        rx,
  uart_rx_fifo_core_if.master         m_if,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overrun,
  output logic                        busy
);
  localparam int      CNT_W    = $clog2(OVERSAMPLE);
  localparam int      IDX_W    = $clog2(DATA_WIDTH) + 1;
  localparam parity_e PAR_MODE = parity_e'(PARITY);
  localparam logic [CNT_W-1:0] S0      = CNT_W'(OVERSAMPLE/2 - 1);
  localparam logic [CNT_W-1:0] S1      = CNT_W'(OVERSAMPLE/2);
  localparam logic [CNT_W-1:0] S2      = CNT_W'(OVERSAMPLE/2 + 1);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(OVERSAMPLE - 1);

  rx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_q, par_d;
  logic                  ferr_q, ferr_d;
  logic [1:0]            smp_q, smp_d;
  logic [1:0]            sync_q;
  logic                  overrun_q;
  logic                  rx_s, vote, push, ferr_new;
  logic                  fifo_full, fifo_empty;
  rx_entry_t             push_entry, head_entry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx};
  end
  assign rx_s = sync_q[1];

  assign vote     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
  assign ferr_new = ferr_q | ~vote;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      ferr_q  <= 1'b0;
      smp_q   <= 2'b11;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      par_q   <= par_d;
      ferr_q  <= ferr_d;
      smp_q   <= smp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    par_d   = par_q;
    ferr_d  = ferr_q;
    smp_d   = smp_q;
    push    = 1'b0;
    if (baud_tick) begin
      if (state_q == ST_IDLE) begin
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = '0;
          idx_d   = '0;
          ferr_d  = 1'b0;
        end
      end else if (state_q == ST_WAIT_IDLE) begin
        if (rx_s) state_d = ST_IDLE;
      end else begin
        cnt_d = (cnt_q == CNT_END) ? '0 : cnt_q + 1'b1;
        if (cnt_q == S0) smp_d[0] = rx_s;
        if (cnt_q == S1) smp_d[1] = rx_s;
        // Mid-bit: the vote is resolved and consumed on this tick.
        if (cnt_q == S2) begin
          case (state_q)
            ST_START:  if (vote) state_d = ST_IDLE;
            ST_DATA: begin
              data_d = {vote, data_q[DATA_WIDTH-1:1]};
              idx_d  = idx_q + 1'b1;
            end
            ST_PARITY: par_d = vote;
            ST_STOP: begin
              ferr_d = ferr_new;
              if (idx_q == IDX_W'(STOP_BITS - 1)) begin
                push    = 1'b1;
                state_d = ferr_new ? ST_WAIT_IDLE : ST_IDLE;
              end else begin
                idx_d = idx_q + 1'b1;
              end
            end
            default: ;
          endcase
        end
        if (cnt_q == CNT_END) begin
          case (state_q)
            ST_START: begin
              state_d = ST_DATA;
              idx_d   = '0;
            end
            ST_DATA: begin
              if (idx_q == IDX_W'(DATA_WIDTH)) begin
                state_d = (PAR_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
                idx_d   = '0;
              end
            end
            ST_PARITY: begin
              state_d = ST_STOP;
              idx_d   = '0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    push_entry            = '0;
    push_entry.data       = MAX_DATA_WIDTH'(data_q);
    push_entry.parity_err = (PAR_MODE != PAR_NONE) &&
                            (par_q != expected_parity(PAR_MODE, MAX_DATA_WIDTH'(data_q)));
    push_entry.frame_err  = ferr_new;
    push_entry.brk        = ferr_new && (data_q == '0) && ((PAR_MODE == PAR_NONE) || !par_q);
  end

  uart_sync_fifo #(
    .WIDTH ($bits(rx_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (push),
    .in_data_i   (push_entry),
    .out_ready_i (m_if.m_ready),
    .out_data_o  (head_entry),
    .level_o     (fifo_level),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Dropped frame: push into a full FIFO with no simultaneous pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overrun_q <= 1'b0;
    else     overrun_q <= push && fifo_full && !m_if.m_ready;
  end

  assign overrun           = overrun_q;
  assign busy              = (state_q != ST_IDLE);
  assign m_if.m_valid      = !fifo_empty;
  assign m_if.m_data       = head_entry.data[DATA_WIDTH-1:0];
  assign m_if.m_parity_err = head_entry.parity_err;
  assign m_if.m_frame_err  = head_entry.frame_err;
  assign m_if.m_break      = head_entry.brk;

endmodule

// File: tb/tb_uart_rx_fifo_core.sv
// Directed bench for uart_rx_fifo_core: 8E1, 16x oversampling, 4-entry FIFO, tick every 4 clk.
module tb_uart_rx_fifo_core;
  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b0;
  logic       rx = 1'b1;
  logic [2:0] fifo_level;
  logic       overrun, busy;
  int         tests_run = 0;
  int         tests_failed = 0;
  int         ovr_seen = 0;
  int         ovr_base;

  uart_rx_fifo_core_if #(.DATA_WIDTH(8)) m_if ();

  uart_rx_fifo_core #(
    .DATA_WIDTH (8),
    .PARITY     (1),
    .STOP_BITS  (1),
    .OVERSAMPLE (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_tick  (baud_tick),
    .rx         (rx),
    .m_if       (m_if.master),
    .fifo_level (fifo_level),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    int tcnt = 0;
    forever begin
      @(negedge clk);
      baud_tick = (tcnt == 3);
      tcnt = (tcnt + 1) % 4;
    end
  end

  always @(posedge clk) if (overrun) ovr_seen <= ovr_seen + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = 0x%0h", tag, got);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    rx = 1'b0; hold(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rx = d[i]; hold(BIT_CLK);
    end
    rx = p; hold(BIT_CLK);
    rx = s; hold(BIT_CLK);
    rx = 1'b1; hold(BIT_CLK/2);
  endtask

  task automatic pop();
    m_if.m_ready = 1'b1;
    hold(1);
    m_if.m_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] ovr_data [5];
    logic       ovr_par  [5];
    ovr_data = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    ovr_par  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    m_if.m_ready = 1'b0;
    hold(5);
    check_eq("rst_valid", 32'(m_if.m_valid), 32'd0);
    check_eq("rst_level", 32'(fifo_level), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_overrun", 32'(overrun), 32'd0);
    check_eq("rst_data", 32'(m_if.m_data), 32'd0);
    rst = 1'b0;
    hold(20);

    // Clean frame, correct even parity.
    send_frame(8'hA5, 1'b0, 1'b1);
    check_eq("a5_valid", 32'(m_if.m_valid), 32'd1);
    check_eq("a5_data", 32'(m_if.m_data), 32'hA5);
    check_eq("a5_perr", 32'(m_if.m_parity_err), 32'd0);
    check_eq("a5_ferr", 32'(m_if.m_frame_err), 32'd0);
    check_eq("a5_break", 32'(m_if.m_break), 32'd0);
    check_eq("a5_level", 32'(fifo_level), 32'd1);
    pop();
    check_eq("a5_pop_level", 32'(fifo_level), 32'd0);

    // Wrong parity bit.
    send_frame(8'h3C, 1'b1, 1'b1);
    check_eq("3c_data", 32'(m_if.m_data), 32'h3C);
    check_eq("3c_perr", 32'(m_if.m_parity_err), 32'd1);
    check_eq("3c_ferr", 32'(m_if.m_frame_err), 32'd0);
    pop();

    // Glitch shorter than half a bit: false start.
    rx = 1'b0; hold(16);
    check_eq("fs_busy_hi", 32'(busy), 32'd1);
    rx = 1'b1; hold(100);
    check_eq("fs_busy_lo", 32'(busy), 32'd0);
    check_eq("fs_level", 32'(fifo_level), 32'd0);
    check_eq("fs_valid", 32'(m_if.m_valid), 32'd0);

    // Line held low for 12 bit-times: one break entry.
    rx = 1'b0; hold(12*BIT_CLK);
    rx = 1'b1; hold(2*BIT_CLK);
    check_eq("brk_level", 32'(fifo_level), 32'd1);
    check_eq("brk_data", 32'(m_if.m_data), 32'h00);
    check_eq("brk_ferr", 32'(m_if.m_frame_err), 32'd1);
    check_eq("brk_break", 32'(m_if.m_break), 32'd1);
    check_eq("brk_busy", 32'(busy), 32'd0);
    pop();
    send_frame(8'h55, 1'b0, 1'b1);
    check_eq("55_data", 32'(m_if.m_data), 32'h55);
    check_eq("55_ferr", 32'(m_if.m_frame_err), 32'd0);
    check_eq("55_break", 32'(m_if.m_break), 32'd0);
    pop();
    check_eq("55_pop_level", 32'(fifo_level), 32'd0);

    // Fill past capacity with the consumer stalled.
    ovr_base = ovr_seen;
    for (int i = 0; i < 5; i++) begin
      send_frame(ovr_data[i], ovr_par[i], 1'b1);
      check_eq($sformatf("ovr_level%0d", i), 32'(fifo_level), (i < 4) ? 32'(i + 1) : 32'd4);
      if (i == 3) check_eq("ovr_none_yet", 32'(ovr_seen - ovr_base), 32'd0);
    end
    check_eq("ovr_pulses", 32'(ovr_seen - ovr_base), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("drain%0d", i), 32'(m_if.m_data), 32'(ovr_data[i]));
      pop();
    end
    check_eq("drain_level", 32'(fifo_level), 32'd0);

    // Reset in the middle of data bit 3.
    send_frame(8'h81, 1'b0, 1'b1);
    check_eq("pre_rst_level", 32'(fifo_level), 32'd1);
    rx = 1'b0; hold(BIT_CLK);
    rx = 1'b1; hold(BIT_CLK);
    rx = 1'b0; hold(BIT_CLK);
    rx = 1'b0; hold(BIT_CLK);
    rx = 1'b0; hold(BIT_CLK/2);
    rst = 1'b1; rx = 1'b1; hold(2);
    rst = 1'b0; hold(200);
    check_eq("mid_rst_valid", 32'(m_if.m_valid), 32'd0);
    check_eq("mid_rst_level", 32'(fifo_level), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    send_frame(8'hC3, 1'b0, 1'b1);
    check_eq("c3_data", 32'(m_if.m_data), 32'hC3);
    check_eq("c3_level", 32'(fifo_level), 32'd1);
    check_eq("c3_perr", 32'(m_if.m_parity_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
